// File: rtl/health_tracker.sv
// Per-player health tracker: hitstun entry detection, saturating damage, iframes, sticky KO and round-over.
// Optional regeneration is compiled in when REGEN_EN is defined.
module health_tracker #(
  parameter int NUM_PLAYERS   = 2,
  parameter int STATE_W       = 4,
  parameter int HITSTUN_STATE = 9,
  parameter int HEALTH_W      = 3,
  parameter int MAX_HEALTH    = 3,
  parameter int DAMAGE        = 1,
  parameter int IFRAME_CYCLES = 30,
  parameter int REGEN_CYCLES  = 600
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            round_start,
  input  logic [NUM_PLAYERS*STATE_W-1:0]  player_state,
  output logic [NUM_PLAYERS*HEALTH_W-1:0] health,
  output logic [NUM_PLAYERS-1:0]          hit_pulse,
  output logic [NUM_PLAYERS-1:0]          ko,
  output logic                            round_over
);

  localparam int IF_W = $clog2((IFRAME_CYCLES > 0 ? IFRAME_CYCLES : 1) + 1);
  localparam logic [HEALTH_W-1:0] HP_MAX  = HEALTH_W'(MAX_HEALTH);
  localparam logic [HEALTH_W-1:0] HP_DMG  = HEALTH_W'(DAMAGE);
  localparam logic [STATE_W-1:0]  HS_CODE = STATE_W'(HITSTUN_STATE);
  localparam logic [IF_W-1:0]     IF_LOAD = IF_W'(IFRAME_CYCLES);
`ifdef REGEN_EN
  localparam int RG_W = $clog2((REGEN_CYCLES > 0 ? REGEN_CYCLES : 1) + 1);
  localparam logic [RG_W-1:0] RG_LAST = RG_W'(REGEN_CYCLES - 1);
`endif

  typedef enum logic [1:0] {ST_ALIVE, ST_IFRAME, ST_KO} life_e;

  life_e                 life       [NUM_PLAYERS];
  logic [HEALTH_W-1:0]   hp         [NUM_PLAYERS];
  logic [HEALTH_W-1:0]   hp_hit     [NUM_PLAYERS];
  logic [IF_W-1:0]       iframe_cnt [NUM_PLAYERS];
`ifdef REGEN_EN
  logic [RG_W-1:0]       regen_cnt  [NUM_PLAYERS];
`endif
  logic [NUM_PLAYERS-1:0] in_hs, prev_hs, entry, accept, ko_hit;

  // round_start outranks any same-cycle hit, so it blocks acceptance here.
  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      in_hs[i]  = (player_state[i*STATE_W +: STATE_W] == HS_CODE);
      entry[i]  = in_hs[i] && !prev_hs[i];
      accept[i] = (life[i] == ST_ALIVE) && entry[i] && !round_over && !round_start;
      hp_hit[i] = (hp[i] > HP_DMG) ? hp[i] - HP_DMG : '0;
      ko_hit[i] = accept[i] && (hp_hit[i] == '0);
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
    assign health[g*HEALTH_W +: HEALTH_W] = hp[g];
  end

  // NOTE: the per-player arrays are a handful of flops, not a RAM, so they take the async reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_hs    <= '1;
      hit_pulse  <= '0;
      ko         <= '0;
      round_over <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        life[i]       <= ST_ALIVE;
        hp[i]         <= HP_MAX;
        iframe_cnt[i] <= '0;
`ifdef REGEN_EN
        regen_cnt[i]  <= '0;
`endif
      end
    end else begin
      prev_hs <= in_hs;
      if (round_start) begin
        hit_pulse  <= '0;
        ko         <= '0;
        round_over <= 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          life[i]       <= ST_ALIVE;
          hp[i]         <= HP_MAX;
          iframe_cnt[i] <= '0;
`ifdef REGEN_EN
          regen_cnt[i]  <= '0;
`endif
        end
      end else begin
        hit_pulse  <= accept;
        round_over <= round_over | (|ko_hit);
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          case (life[i])
            ST_ALIVE: begin
              if (accept[i]) begin
                hp[i] <= hp_hit[i];
`ifdef REGEN_EN
                regen_cnt[i] <= '0;
`endif
                if (ko_hit[i]) begin
                  life[i] <= ST_KO;
                  ko[i]   <= 1'b1;
                end else if (IFRAME_CYCLES > 0) begin
                  life[i]       <= ST_IFRAME;
                  iframe_cnt[i] <= IF_LOAD;
                end
              end
`ifdef REGEN_EN
              else if (round_over || hp[i] >= HP_MAX) begin
                regen_cnt[i] <= '0;
              end else if (regen_cnt[i] == RG_LAST) begin
                regen_cnt[i] <= '0;
                hp[i]        <= hp[i] + HEALTH_W'(1);
              end else begin
                regen_cnt[i] <= regen_cnt[i] + RG_W'(1);
              end
`endif
            end
            ST_IFRAME: begin
              // Leave on the edge where the counter hits zero; entries during the window are dropped.
              if (iframe_cnt[i] <= IF_W'(1)) begin
                iframe_cnt[i] <= '0;
                life[i]       <= ST_ALIVE;
              end else begin
                iframe_cnt[i] <= iframe_cnt[i] - IF_W'(1);
              end
`ifdef REGEN_EN
              regen_cnt[i] <= '0;
`endif
            end
            ST_KO: begin
              hp[i] <= '0;
`ifdef REGEN_EN
              regen_cnt[i] <= '0;
`endif
            end
            default: life[i] <= ST_ALIVE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_health_tracker.sv
// Directed bench for health_tracker: a default instance and one with DAMAGE=2, IFRAME_CYCLES=4, REGEN_CYCLES=8.
module tb_health_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       rs_a, rs_b;
  logic [7:0] state_a, state_b;
  logic [5:0] health_a, health_b;
  logic [1:0] hit_a, hit_b, ko_a, ko_b;
  logic       ro_a, ro_b;

  int errors = 0;
  int checks = 0;

`ifdef REGEN_EN
  localparam logic [2:0] HP_REGEN1 = 3'd2;
  localparam logic [2:0] HP_REGEN2 = 3'd3;
`else
  localparam logic [2:0] HP_REGEN1 = 3'd1;
  localparam logic [2:0] HP_REGEN2 = 3'd1;
`endif

  always #5 clk = ~clk;

  health_tracker dut_a (
    .clk(clk), .rst(rst), .round_start(rs_a), .player_state(state_a),
    .health(health_a), .hit_pulse(hit_a), .ko(ko_a), .round_over(ro_a)
  );

  health_tracker #(.DAMAGE(2), .IFRAME_CYCLES(4), .REGEN_CYCLES(8)) dut_b (
    .clk(clk), .rst(rst), .round_start(rs_b), .player_state(state_b),
    .health(health_b), .hit_pulse(hit_b), .ko(ko_b), .round_over(ro_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rs_a = 1'b0; rs_b = 1'b0;
    state_a = {4'd0, 4'd9};
    state_b = 8'h00;
    #1;
    check("reset_health_a", 32'(health_a), 32'({3'd3, 3'd3}));
    check("reset_flags_a", 32'({hit_a, ko_a, ro_a}), 32'd0);
    check("reset_health_b", 32'(health_b), 32'({3'd3, 3'd3}));
    tick();
    rst = 1'b0;

    // Test 1: p0 held in hitstun through reset release is not a hit
    tick();
    check("t1_no_hit_held", 32'(hit_a), 32'd0);
    check("t1_health_held", 32'(health_a), 32'({3'd3, 3'd3}));
    state_a = {4'd0, 4'd0}; tick();
    state_a = {4'd0, 4'd9}; tick();
    check("t1_hit_pulse", 32'(hit_a), 32'b01);
    check("t1_health", 32'(health_a), 32'({3'd3, 3'd2}));
    tick();
    check("t1_pulse_falls", 32'(hit_a), 32'd0);
    check("t1_no_retrigger", 32'(health_a), 32'({3'd3, 3'd2}));

    // Test 2: p1 iframe window of 30 cycles
    state_a = {4'd9, 4'd0}; tick();
    check("t2_hit1", 32'({hit_a, health_a}), 32'({2'b10, 3'd2, 3'd2}));
    state_a = 8'h00; tick_n(9);
    state_a = {4'd9, 4'd0}; tick();
    check("t2_iframe_ignored", 32'({hit_a, health_a}), 32'({2'b00, 3'd2, 3'd2}));
    state_a = 8'h00; tick_n(19);
    state_a = {4'd9, 4'd0}; tick();
    check("t2_last_iframe_edge", 32'({hit_a, health_a}), 32'({2'b00, 3'd2, 3'd2}));
    state_a = 8'h00; tick();
    state_a = {4'd9, 4'd0}; tick();
    check("t2_hit2", 32'({hit_a, health_a}), 32'({2'b10, 3'd1, 3'd2}));
    check("t2_no_ko", 32'({ko_a, ro_a}), 32'd0);

    // Test 5: round_start beats a same-cycle p0 entry
    state_a = {4'd0, 4'd9}; rs_a = 1'b1; tick();
    rs_a = 1'b0;
    check("t5_health", 32'(health_a), 32'({3'd3, 3'd3}));
    check("t5_flags", 32'({hit_a, ko_a, ro_a}), 32'd0);
    tick();
    check("t5_no_spurious", 32'({hit_a, health_a}), 32'({2'b00, 3'd3, 3'd3}));

    // Test 3: DAMAGE=2 saturates to 0, KO and round_over, later hit ignored
    state_b = {4'd0, 4'd9}; tick();
    check("t3_hit1", 32'({hit_b, health_b}), 32'({2'b01, 3'd3, 3'd1}));
    state_b = 8'h00; tick_n(5);
    state_b = {4'd0, 4'd9}; tick();
    check("t3_hit2_sat", 32'({hit_b, health_b}), 32'({2'b01, 3'd3, 3'd0}));
    check("t3_ko", 32'({ko_b, ro_b}), 32'({2'b01, 1'b1}));
    state_b = {4'd9, 4'd0}; tick();
    check("t3_p1_ignored", 32'({hit_b, health_b}), 32'({2'b00, 3'd3, 3'd0}));
    tick_n(20);
    check("t3_ko_sticky", 32'({ko_b, ro_b, health_b}), 32'({2'b01, 1'b1, 3'd3, 3'd0}));

    // Test 4: simultaneous KO is a draw
    state_b = 8'h00; rs_b = 1'b1; tick();
    rs_b = 1'b0;
    check("t4_restart", 32'({ko_b, ro_b, health_b}), 32'({2'b00, 1'b0, 3'd3, 3'd3}));
    state_b = {4'd9, 4'd9}; tick();
    check("t4_both_hit", 32'({hit_b, health_b}), 32'({2'b11, 3'd1, 3'd1}));
    state_b = 8'h00; tick_n(5);
    state_b = {4'd9, 4'd9}; tick();
    check("t4_draw", 32'({ko_b, ro_b, health_b}), 32'({2'b11, 1'b1, 3'd0, 3'd0}));

    // Test 6: regeneration (only when compiled in)
    state_b = 8'h00; rs_b = 1'b1; tick();
    rs_b = 1'b0;
    state_b = {4'd0, 4'd9}; tick();
    check("t6_hit", 32'(health_b), 32'({3'd3, 3'd1}));
    state_b = 8'h00; tick_n(11);
    check("t6_before_regen", 32'(health_b), 32'({3'd3, 3'd1}));
    tick();
    check("t6_regen1", 32'(health_b), 32'({3'd3, HP_REGEN1}));
    tick_n(8);
    check("t6_regen2", 32'(health_b), 32'({3'd3, HP_REGEN2}));
    tick_n(10);
    check("t6_regen_cap", 32'(health_b), 32'({3'd3, HP_REGEN2}));

    // Async reset mid-round clears state between edges
    state_a = {4'd0, 4'd0}; tick();
    state_a = {4'd0, 4'd9}; tick();
    check("mid_hit", 32'({hit_a, health_a}), 32'({2'b01, 3'd3, 3'd2}));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_health", 32'(health_a), 32'({3'd3, 3'd3}));
    check("mid_rst_pulse", 32'({hit_a, ko_a, ro_a}), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
